// File: rtl/sound_frame_sequencer_pkg.sv
// Shared sound constants: divider default, per-step strobe maps and length counter limits.
package sound_frame_sequencer_pkg;

  localparam int CLKS_PER_STEP_DEFAULT = 64453;
  localparam int DIV_W = 17;

  localparam logic [2:0] STEP_RESET = 3'd7;

  // Bit n set means the strobe fires on entering step n.
  localparam logic [7:0] LEN_STEPS   = 8'b0101_0101;
  localparam logic [7:0] SWEEP_STEPS = 8'b0100_0100;
  localparam logic [7:0] ENV_STEPS   = 8'b1000_0000;

  localparam int LEN_MAX_SHORT = 64;
  localparam int LEN_MAX_WAVE  = 256;
  localparam int LEN_W_SHORT   = 6;
  localparam int LEN_W_WAVE    = 8;

  typedef struct packed {
    logic len;
    logic sweep;
    logic env;
  } strobes_t;

  function automatic strobes_t strobes_for_step(input logic [2:0] step);
    strobes_t s;
    s.len   = LEN_STEPS[step];
    s.sweep = SWEEP_STEPS[step];
    s.env   = ENV_STEPS[step];
    return s;
  endfunction

endpackage

// File: rtl/sound_length_counter.sv
// One channel length counter; one extra bit above W holds the full MAX value.
module sound_length_counter
  import sound_frame_sequencer_pkg::*;
#(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] data,
  input  logic         trigger,
  input  logic         len_en,
  input  logic         len_tick,
  output logic         active,
  output logic         expired
);

  localparam logic [W:0] MAX = (W == LEN_W_WAVE) ? (W+1)'(LEN_MAX_WAVE) : (W+1)'(LEN_MAX_SHORT);
  localparam logic [W:0] ONE = (W+1)'(1);

  logic [W:0] cnt_q, cnt_d, loaded;
  logic       expired_q, expired_d;

  // Load/trigger take priority over the length tick; trigger only refills an empty counter.
  always_comb begin
    cnt_d     = cnt_q;
    expired_d = 1'b0;
    loaded    = cnt_q;
    if (load) loaded = MAX - {1'b0, data};
    if (trigger && loaded == '0) loaded = MAX;
    if (load || trigger) begin
      cnt_d = loaded;
    end else if (len_tick && len_en && cnt_q != '0) begin
      cnt_d     = cnt_q - ONE;
      expired_d = (cnt_q == ONE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      expired_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      expired_q <= expired_d;
    end
  end

  assign active  = (cnt_q != '0);
  assign expired = expired_q;

endmodule

// File: rtl/sound_frame_sequencer.sv
// 512 Hz frame sequencer with length/sweep/envelope strobes.
// Length counters are compiled in only when SOUND_SEQ_LENGTH_EN is defined.
module sound_frame_sequencer
  import sound_frame_sequencer_pkg::*;
#(
  parameter int CLKS_PER_STEP = CLKS_PER_STEP_DEFAULT
) (
  input  logic       I_CLK,
  input  logic       I_RESET,
  input  logic       I_MASTER_EN,
  input  logic       I_DIV_RESET,
  input  logic [3:0] I_LEN_LOAD,
  input  logic [7:0] I_LEN_DATA,
  input  logic [3:0] I_LEN_EN,
  input  logic [3:0] I_TRIGGER,
  output logic [2:0] O_STEP,
  output logic       O_LEN_TICK,
  output logic       O_SWEEP_TICK,
  output logic       O_ENV_TICK,
  output logic [3:0] O_LEN_ACTIVE,
  output logic [3:0] O_LEN_EXPIRED
);

  localparam logic [DIV_W-1:0] DIV_TC  = DIV_W'(CLKS_PER_STEP - 1);
  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       step_q, step_d;
  strobes_t         strb_q, strb_d;

  // Master off parks the sequencer at step 7 so the first step after enable is 0.
  always_comb begin
    div_d  = div_q;
    step_d = step_q;
    strb_d = '0;
    if (!I_MASTER_EN) begin
      div_d  = '0;
      step_d = STEP_RESET;
    end else if (I_DIV_RESET) begin
      div_d = '0;
    end else if (div_q == DIV_TC) begin
      div_d  = '0;
      step_d = step_q + 3'd1;
      strb_d = strobes_for_step(step_d);
    end else begin
      div_d = div_q + DIV_ONE;
    end
  end

  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      div_q  <= '0;
      step_q <= STEP_RESET;
      strb_q <= '0;
    end else begin
      div_q  <= div_d;
      step_q <= step_d;
      strb_q <= strb_d;
    end
  end

  assign O_STEP       = step_q;
  assign O_LEN_TICK   = strb_q.len;
  assign O_SWEEP_TICK = strb_q.sweep;
  assign O_ENV_TICK   = strb_q.env;

`ifdef SOUND_SEQ_LENGTH_EN
  // Channel 3 (index 2) is the wave channel with the wider 8-bit length.
  for (genvar n = 0; n < 4; n++) begin : g_len
    localparam int W = (n == 2) ? LEN_W_WAVE : LEN_W_SHORT;
    sound_length_counter #(.W(W)) u_len (
      .clk      (I_CLK),
      .rst      (I_RESET),
      .load     (I_LEN_LOAD[n]),
      .data     (I_LEN_DATA[W-1:0]),
      .trigger  (I_TRIGGER[n]),
      .len_en   (I_LEN_EN[n]),
      .len_tick (strb_q.len),
      .active   (O_LEN_ACTIVE[n]),
      .expired  (O_LEN_EXPIRED[n])
    );
  end
`else
  logic unused_len;
  assign unused_len    = ^{I_LEN_LOAD, I_LEN_DATA, I_LEN_EN, I_TRIGGER};
  assign O_LEN_ACTIVE  = '0;
  assign O_LEN_EXPIRED = '0;
`endif

endmodule

// File: doc/sound_frame_sequencer.md
SOUND_FRAME_SEQUENCER -- requirements
Module: sound_frame_sequencer

Interface
REQ-001 SHALL have parameter CLKS_PER_STEP, default 64453, meaning I_CLK cycles per 512 Hz sequencer step; legal range 2..131071.
REQ-002 SHALL have port I_CLK  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port I_RESET  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port I_MASTER_EN  input  1  NR52 bit 7 sound master enable.
REQ-005 SHALL have port I_DIV_RESET  input  1  one-cycle pulse; DIV register write.
REQ-006 SHALL have port I_LEN_LOAD  input  4  per-channel pulse; NRx1 length write (bit n = channel n+1).
REQ-007 SHALL have port I_LEN_DATA  input  8  length value; channels 1, 2, 4 use [5:0], channel 3 uses [7:0].
REQ-008 SHALL have port I_LEN_EN  input  4  per-channel NRx4 bit 6 length enable, level.
REQ-009 SHALL have port I_TRIGGER  input  4  per-channel pulse; NRx4 bit 7 write.
REQ-010 SHALL have port O_STEP  output  3  current sequencer step 0..7.
REQ-011 SHALL have port O_LEN_TICK  output  1  one-cycle 256 Hz length strobe.
REQ-012 SHALL have port O_SWEEP_TICK  output  1  one-cycle 128 Hz sweep strobe.
REQ-013 SHALL have port O_ENV_TICK  output  1  one-cycle 64 Hz envelope strobe.
REQ-014 SHALL have port O_LEN_ACTIVE  output  4  per-channel length counter nonzero.
REQ-015 SHALL have port O_LEN_EXPIRED  output  4  per-channel one-cycle pulse, length counter reached 0; channel disables itself.

Function
REQ-016 Divider SHALL count 0..CLKS_PER_STEP-1 while I_MASTER_EN=1; at terminal count it SHALL wrap to 0 and step SHALL advance (7 wraps to 0).
REQ-017 Strobes SHALL be registered, asserted exactly in the cycle O_STEP shows the newly entered step, for one cycle.
REQ-018 O_LEN_TICK SHALL pulse on entering steps 0, 2, 4, 6; O_SWEEP_TICK on steps 2, 6; O_ENV_TICK on step 7.
REQ-019 While I_MASTER_EN=0: divider held 0, step held 7, no strobes, length counters frozen (not cleared), loads/triggers still accepted.
REQ-020 On I_MASTER_EN 0->1 the first step entered SHALL be 0, CLKS_PER_STEP cycles after the rising edge.
REQ-021 I_DIV_RESET SHALL clear the divider to 0 without changing step; coincident with terminal count, I_DIV_RESET wins (no advance, no strobe).
REQ-022 I_LEN_LOAD[n] SHALL set counter n = MAX_n - data, MAX = 256 for channel 3, 64 otherwise; data 0 yields MAX.
REQ-023 I_TRIGGER[n] with counter n = 0 SHALL reload MAX_n; nonzero counter unchanged.
REQ-024 In a cycle with O_LEN_TICK=1, each counter with I_LEN_EN[n]=1 and value nonzero SHALL decrement by 1; reaching 0 SHALL pulse O_LEN_EXPIRED[n] the following cycle.
REQ-025 Load or trigger coincident with O_LEN_TICK for the same channel: load/trigger SHALL win, no decrement that cycle; load and trigger together: load then trigger-reload rule applied to loaded value.
REQ-026 O_LEN_ACTIVE[n] SHALL be combinational (counter n != 0).

Reset
REQ-027 I_RESET SHALL immediately force divider 0, step 7 (O_STEP=7), all strobes 0, length counters 0, O_LEN_ACTIVE 0, O_LEN_EXPIRED 0.
REQ-028 Reset asserted mid-step SHALL discard partial divider count; after release behaviour per REQ-020.

Configuration
REQ-029 Macro SOUND_SEQ_LENGTH_EN SHALL compile in the four length counters (REQ-022..026).
REQ-030 Without SOUND_SEQ_LENGTH_EN: O_LEN_ACTIVE and O_LEN_EXPIRED SHALL be constant 0, I_LEN_* and I_TRIGGER ignored, sequencer strobes unchanged.

Structure
REQ-031 Shared sound package SHALL hold CLKS_PER_STEP default, step encodings for length/sweep/envelope, and length MAX constants (64, 256).
REQ-032 One sub-module sound_length_counter SHALL be instantiated four times, parameterised by counter width (6 or 8 bits, plus zero flag).

Verification
REQ-033 CLKS_PER_STEP=4, master on from reset: O_STEP 0,1,..,7,0 every 4 cycles; LEN ticks at 0,2,4,6, SWEEP at 2,6, ENV at 7 only.
REQ-034 Load ch1 data 62, LEN_EN=1: O_LEN_ACTIVE[0]=1; after 2 LEN ticks O_LEN_EXPIRED[0] pulses once, ACTIVE drops to 0.
REQ-035 Load ch3 data 0 -> counter 256; trigger with counter 0 on ch2 -> counter 64; trigger with counter 5 -> stays 5.
REQ-036 Master off at step 3 with counter 10: no ticks, counter stays 10; master on -> step 0 after 4 cycles with LEN tick.
REQ-037 DIV_RESET coincident with terminal count: step unchanged, no strobe, next advance 4 cycles later; load coincident with LEN tick: loaded value, no decrement.
REQ-038 Reset asserted mid-step and mid-count: all outputs to reset values same cycle; build without SOUND_SEQ_LENGTH_EN: expired/active always 0.
